// File: rtl/w10_product_streamer.sv
// Streams 256 pixel/weight pairs from external memories and emits a registered
// signed product per element, framed by accumulator clear, latch and done strobes.
module w10_product_streamer #(
  parameter int XW = 8,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  output logic [7:0]    addr,
  input  logic [XW-1:0] x_data,
  input  logic [WW-1:0] w_data,
  output logic          acc_clr,
  output logic          sum_en,
  output logic [7:0]    count,
  output logic [15:0]   prod,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, FLUSH, DONE} state_t;

  state_t      state;
  logic [1:0]  flush_cnt;
  logic        op_valid;
  logic [7:0]  op_idx;
  logic [15:0] x_ext;
  logic [15:0] w_ext;
  logic [15:0] mult;

  // Pixel is unsigned, so zero-extend; the 16-bit product is exact for XW+WW <= 16.
  always_comb begin
    x_ext = {{(16-XW){1'b0}}, x_data};
    w_ext = {{(16-WW){w_data[WW-1]}}, w_data};
    mult  = x_ext * w_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= 8'd0;
      acc_clr   <= 1'b0;
      sum_en    <= 1'b0;
      count     <= 8'd0;
      prod      <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      flush_cnt <= 2'd0;
      op_valid  <= 1'b0;
      op_idx    <= 8'd0;
    end else begin
      // op_valid/op_idx track the address issued last cycle, whose data is present now
      op_valid <= (state == CLR) || (state == RUN);
      op_idx   <= addr;
      sum_en   <= op_valid;
      prod     <= op_valid ? mult : 16'd0;
      count    <= op_valid ? op_idx : 8'd0;
      acc_clr  <= 1'b0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            state   <= CLR;
            acc_clr <= 1'b1;
            busy    <= 1'b1;
            addr    <= 8'd0;
          end
        end
        CLR: begin
          state <= RUN;
          addr  <= 8'd1;
        end
        RUN: begin
          if (addr == 8'd255) begin
            state     <= FLUSH;
            addr      <= 8'd0;
            flush_cnt <= 2'd0;
          end else begin
            addr <= addr + 8'd1;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 2'd1;
          // Second latch strobe: the accumulator now includes element 255
          if (flush_cnt == 2'd1) begin
            count <= 8'd255;
          end
          if (flush_cnt == 2'd2) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_w10_product_streamer.sv
// Scoreboard bench for w10_product_streamer with memory and accumulator models.
module tb_w10_product_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  addr;
  logic [7:0]  x_data = 8'd0;
  logic [7:0]  w_data = 8'd0;
  logic        acc_clr, sum_en, busy, done;
  logic [7:0]  count;
  logic [15:0] prod;

  always #5 clk = ~clk;

  w10_product_streamer #(.XW(8), .WW(8)) dut (
    .clk(clk), .rst(rst), .go(go), .addr(addr), .x_data(x_data), .w_data(w_data),
    .acc_clr(acc_clr), .sum_en(sum_en), .count(count), .prod(prod),
    .busy(busy), .done(done)
  );

  logic [7:0] xmem [256];
  logic [7:0] wmem [256];

  always @(posedge clk) begin
    x_data <= xmem[addr];
    w_data <= wmem[addr];
  end

  // Downstream accumulator: clears on acc_clr|rst, latches on count==255
  logic signed [23:0] acc_sum, acc_out;
  always @(posedge clk) begin
    if (rst || acc_clr) acc_sum <= 24'sd0;
    else if (sum_en) acc_sum <= acc_sum + {{8{prod[15]}}, prod};
    if (rst) acc_out <= 24'sd0;
    else if (count == 8'd255) acc_out <= acc_sum;
  end

  typedef struct {int idx; int p;} exp_t;
  exp_t   q[$];
  exp_t   e;
  int     checks = 0, errors = 0;
  longint exp_sum;

  task automatic chk(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_en = 0, in_frame = 0;
  int t_clr = -1000, t_done = 0, done_cnt = 0, clr_cnt = 0, en_cnt = 0, rel;

  always @(negedge clk) begin
    if (mon_en) begin
      rel = cyc - t_clr;
      if (acc_clr) begin
        t_clr = cyc; rel = 0; in_frame = 1; en_cnt = 0; clr_cnt++;
        chk("clr_busy", busy, 1);
      end
      chk("addr", addr, (in_frame && rel <= 255) ? rel : 0);
      if (sum_en) begin
        en_cnt++;
        if (q.size() == 0) chk("q_under", 1, 0);
        else begin
          e = q.pop_front();
          chk("count", count, e.idx);
          chk("prod", longint'($signed(prod)), e.p);
        end
      end else begin
        chk("prod_idle", prod, 0);
      end
      if (in_frame && rel == 258) chk("latch_cnt", count, 255);
      if (done) begin
        done_cnt++; t_done = cyc; in_frame = 0;
        chk("done_busy", busy, 0);
        chk("done_count", count, 0);
      end
      if (rst) begin
        in_frame = 0;
        q.delete();
      end
    end
  end

  task automatic load(input int pat);
    logic [7:0] x, w;
    int p;
    exp_sum = 0;
    for (int k = 0; k < 256; k++) begin
      case (pat)
        0: begin x = 8'd1; w = 8'd1; end
        1: begin x = 8'd255; w = 8'h80; end
        2: begin x = 8'(k); w = k[0] ? 8'hFF : 8'h01; end
        default: begin x = 8'($urandom_range(0, 255)); w = 8'($urandom_range(0, 255)); end
      endcase
      xmem[k] = x;
      wmem[k] = w;
      p = int'(x) * int'($signed(w));
      q.push_back('{k, p});
      exp_sum += p;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int pat, input bit disturb, output int td);
    int d0, c0;
    longint es;
    load(pat);
    es = exp_sum; d0 = done_cnt; c0 = clr_cnt;
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
      go = disturb && (cyc == t_clr + 5 || cyc == t_clr + 100);
    end
    go = 1'b0;
    chk("done_seen", done_cnt - d0, 1);
    chk("clr_seen", clr_cnt - c0, 1);
    chk("done_lat", t_done - t_clr, 259);
    chk("en_cnt", en_cnt, 256);
    chk("sum", acc_out, es);
    chk("q_empty", q.size(), 0);
    td = t_done;
    $display("frame pat=%0d disturb=%0d sum=%0d expected=%0d done_cycle=%0d",
             pat, disturb, acc_out, es, t_done);
  endtask

  initial begin
    int td1, td2, c;
    for (int k = 0; k < 256; k++) begin xmem[k] = 8'd0; wmem[k] = 8'd0; end
    idle(3);
    chk("rst_addr", addr, 0);   chk("rst_clr", acc_clr, 0); chk("rst_en", sum_en, 0);
    chk("rst_count", count, 0); chk("rst_prod", prod, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0; mon_en = 1;
    idle(1);

    frame(0, 0, td1);
    idle(3);
    frame(1, 0, td1);
    idle(3);
    c = clr_cnt;
    frame(2, 1, td1);
    idle(20);
    chk("ignored_go", clr_cnt - c, 1);

    // Abort mid-frame at count 100
    load(2);
    c = done_cnt;
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    for (int i = 0; i < 400 && !(sum_en && count == 8'd100); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_reach", count, 100);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_addr", addr, 0);   chk("abort_clr", acc_clr, 0); chk("abort_en", sum_en, 0);
    chk("abort_count", count, 0); chk("abort_prod", prod, 0);   chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    idle(300);
    chk("abort_nodone", done_cnt - c, 0);
    $display("abort at count=100 done_pulses=%0d", done_cnt - c);
    frame(3, 0, td1);

    // go together with rst must be dropped
    idle(2);
    c = clr_cnt;
    rst = 1'b1; go = 1'b1;
    @(posedge clk); #1 rst = 1'b0; go = 1'b0;
    idle(5);
    chk("go_rst", clr_cnt - c, 0);
    chk("go_rst_busy", busy, 0);
    $display("go with rst: frames started=%0d", clr_cnt - c);

    // Back-to-back: second go on the first IDLE cycle after done
    idle(3);
    frame(2, 0, td1);
    frame(3, 0, td2);
    chk("b2b_period", td2 - td1, 261);

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
